// File: rtl/cordic_acc_pkg.sv
// Shared definitions for cordic_acc_slave: register offsets, STATUS layout
// and the tag carried alongside each sample through the square pipeline.
package cordic_acc_pkg;

  localparam logic [1:0] RegData   = 2'd0;
  localparam logic [1:0] RegResult = 2'd1;
  localparam logic [1:0] RegStatus = 2'd2;
  localparam logic [1:0] RegRsvd   = 2'd3;

  localparam int unsigned StatusBusyBit = 0;
  localparam int unsigned StatusPendLsb = 1;
  localparam int unsigned StatusPendW   = 7;
  localparam int unsigned StatusCntLsb  = 8;
  localparam int unsigned StatusCntW    = 16;
  localparam int unsigned StatusOvfBit  = 24;

  // Wide enough for the largest supported channel count (16).
  localparam int unsigned MaxChW = 4;

  typedef struct packed {
    logic              valid;
    logic [MaxChW-1:0] ch;
  } pipe_tag_t;

endpackage

// File: rtl/cordic_acc_slave_square_pipe.sv
// square_pipe: computes (x*x) >>> FRAC_W and delays it LAT cycles together
// with its valid/channel tag.
module square_pipe
  import cordic_acc_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned FRAC_W = 16,
  parameter int unsigned LAT    = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  pipe_tag_t         in_tag,
  input  logic [DATA_W-1:0] in_data,
  output pipe_tag_t         out_tag,
  output logic [DATA_W-1:0] out_term
);

  logic signed [2*DATA_W-1:0] x_ext;
  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]          term;

  pipe_tag_t         tag_q  [LAT];
  logic [DATA_W-1:0] term_q [LAT];

  assign x_ext = {{DATA_W{in_data[DATA_W-1]}}, in_data};
  assign prod  = x_ext * x_ext;
  assign term  = DATA_W'(prod >>> FRAC_W);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(LAT); i++) begin
        tag_q[i]  <= '0;
        term_q[i] <= '0;
      end
    end else begin
      tag_q[0]  <= in_tag;
      term_q[0] <= term;
      for (int i = 1; i < int'(LAT); i++) begin
        tag_q[i]  <= tag_q[i-1];
        term_q[i] <= term_q[i-1];
      end
    end
  end

  assign out_tag  = tag_q[LAT-1];
  assign out_term = term_q[LAT-1];

endmodule

// File: rtl/cordic_acc_slave.sv
// Multi-channel sum-of-squares accumulator behind an Avalon-MM slave.
// Define CORDIC_ACC_SATURATE_EN for saturating accumulation with sticky OVF.
module cordic_acc_slave
  import cordic_acc_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned FRAC_W   = 16,
  parameter int unsigned TERM_LAT = 6,
  localparam int unsigned ADDR_W  = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid
);

  localparam int unsigned PendW = $clog2(TERM_LAT + 2);

  logic [MaxChW-1:0] addr_ch;
  logic [1:0]        addr_reg;
  logic              ch_ok, inject, clear_any;
  pipe_tag_t         in_tag, out_tag;
  logic [DATA_W-1:0] out_term;

  logic [DATA_W-1:0] acc_q  [NUM_CH];
  logic [DATA_W-1:0] acc_d  [NUM_CH];
  logic [15:0]       cnt_q  [NUM_CH];
  logic [15:0]       cnt_d  [NUM_CH];
  logic [PendW-1:0]  pend_q [NUM_CH];
  logic [PendW-1:0]  pend_d [NUM_CH];
`ifdef CORDIC_ACC_SATURATE_EN
  logic [NUM_CH-1:0] ovf_q, ovf_d;
`endif
  logic [NUM_CH-1:0] clr_vec, inj_vec, emg_vec;
  logic [DATA_W-1:0] rd_sel, readdata_q;
  logic [31:0]       status;
  logic              readdatavalid_q;

  assign addr_ch   = MaxChW'(address >> 2);
  assign addr_reg  = address[1:0];
  assign ch_ok     = 32'(addr_ch) < NUM_CH;
  assign inject    = write && ch_ok && (addr_reg == RegData);
  assign clear_any = write && ch_ok && (addr_reg == RegResult);
  assign in_tag    = '{valid: inject, ch: addr_ch};

  square_pipe #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .LAT    (TERM_LAT)
  ) u_square_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_tag   (in_tag),
    .in_data  (writedata),
    .out_tag  (out_tag),
    .out_term (out_term)
  );

  always_comb begin
    clr_vec = '0;
    inj_vec = '0;
    emg_vec = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      clr_vec[c] = clear_any && (addr_ch == MaxChW'(c));
      inj_vec[c] = inject && (addr_ch == MaxChW'(c));
      emg_vec[c] = out_tag.valid && (out_tag.ch == MaxChW'(c));
    end
  end

  // Clear is applied before the emerging term, so a coincident term survives.
  always_comb begin
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] sum;
    logic [15:0]       cnt_base;
    base     = '0;
    sum      = '0;
    cnt_base = '0;
`ifdef CORDIC_ACC_SATURATE_EN
    ovf_d    = '0;
`endif
    for (int c = 0; c < int'(NUM_CH); c++) begin
      base     = clr_vec[c] ? '0 : acc_q[c];
      cnt_base = clr_vec[c] ? '0 : cnt_q[c];
      sum      = base + out_term;
      acc_d[c] = base;
      cnt_d[c] = cnt_base;
`ifdef CORDIC_ACC_SATURATE_EN
      ovf_d[c] = !clr_vec[c] && ovf_q[c];
`endif
      if (emg_vec[c]) begin
`ifdef CORDIC_ACC_SATURATE_EN
        if ((base[DATA_W-1] == out_term[DATA_W-1]) && (sum[DATA_W-1] != base[DATA_W-1])) begin
          acc_d[c] = base[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
          ovf_d[c] = 1'b1;
        end else begin
          acc_d[c] = sum;
        end
`else
        acc_d[c] = sum;
`endif
        cnt_d[c] = cnt_base + 16'd1;
      end
      pend_d[c] = pend_q[c] + PendW'(inj_vec[c]) - PendW'(emg_vec[c]);
    end
  end

  always_comb begin
    rd_sel = '0;
    status = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (addr_ch == MaxChW'(c)) begin
        status[StatusBusyBit]                = pend_q[c] != '0;
        status[StatusPendLsb +: StatusPendW] = StatusPendW'(pend_q[c]);
        status[StatusCntLsb +: StatusCntW]   = cnt_q[c];
`ifdef CORDIC_ACC_SATURATE_EN
        status[StatusOvfBit]                 = ovf_q[c];
`endif
        case (addr_reg)
          RegResult: rd_sel = acc_q[c];
          RegStatus: rd_sel = DATA_W'(status);
          default:   rd_sel = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        acc_q[c]  <= '0;
        cnt_q[c]  <= '0;
        pend_q[c] <= '0;
      end
`ifdef CORDIC_ACC_SATURATE_EN
      ovf_q <= '0;
`endif
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        acc_q[c]  <= acc_d[c];
        cnt_q[c]  <= cnt_d[c];
        pend_q[c] <= pend_d[c];
      end
`ifdef CORDIC_ACC_SATURATE_EN
      ovf_q <= ovf_d;
`endif
      readdata_q      <= read ? rd_sel : '0;
      readdatavalid_q <= read;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = readdatavalid_q;

endmodule

// File: tb/tb_cordic_acc_slave.sv
// Self-checking bench for cordic_acc_slave: constant-table vectors, directed
// multi-cycle sequences and random traffic against a time-stamped model.
module tb_cordic_acc_slave;
  import cordic_acc_pkg::*;

  localparam int unsigned NumCh = 4;
  localparam int unsigned DataW = 32;
  localparam int unsigned FracW = 16;
  localparam int unsigned Lat   = 6;
  localparam int unsigned AddrW = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             read = 1'b0;
  logic             write = 1'b0;
  logic [AddrW-1:0] address = '0;
  logic [31:0]      writedata = '0;
  logic [31:0]      readdata;
  logic             readdatavalid;

  cordic_acc_slave #(
    .NUM_CH   (NumCh),
    .DATA_W   (DataW),
    .FRAC_W   (FracW),
    .TERM_LAT (Lat)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: samples queued with the cycle on which they land.
  typedef struct {
    int          due;
    int          ch;
    logic [31:0] term;
  } item_t;

  item_t       inflight[$];
  logic [31:0] m_acc [NumCh];
  logic [15:0] m_cnt [NumCh];
  logic        m_ovf [NumCh];
  int          now = 0;

  function automatic logic [31:0] sq_term(input logic [31:0] x);
    longint xs, p;
    xs = longint'($signed(x));
    p  = xs * xs;
    return 32'(p >>> FracW);
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    int          ch, pend;
    logic [31:0] v;
    ch   = int'(a[3:2]);
    pend = 0;
    v    = 32'h0;
    foreach (inflight[i]) if (inflight[i].ch == ch) pend++;
    if (a[1:0] == RegResult) v = m_acc[ch];
    if (a[1:0] == RegStatus)
      v = (32'(m_ovf[ch]) << 24) | (32'(m_cnt[ch]) << 8) | (32'(pend) << 1) | 32'(pend != 0);
    return v;
  endfunction

  task automatic model_add(input int ch, input logic [31:0] t);
    longint s;
    s = longint'($signed(m_acc[ch])) + longint'($signed(t));
`ifdef CORDIC_ACC_SATURATE_EN
    if (s > 64'sd2147483647) begin
      s = 64'sd2147483647;
      m_ovf[ch] = 1'b1;
    end else if (s < -64'sd2147483648) begin
      s = -64'sd2147483648;
      m_ovf[ch] = 1'b1;
    end
`endif
    m_acc[ch] = 32'(s);
    m_cnt[ch] = m_cnt[ch] + 16'd1;
  endtask

  task automatic model_step(input logic w, input logic [3:0] a, input logic [31:0] d);
    int ch;
    ch = int'(a[3:2]);
    if (w && a[1:0] == RegResult) begin
      m_acc[ch] = '0;
      m_cnt[ch] = '0;
      m_ovf[ch] = 1'b0;
    end
    for (int i = inflight.size() - 1; i >= 0; i--) begin
      if (inflight[i].due == now) begin
        model_add(inflight[i].ch, inflight[i].term);
        inflight.delete(i);
      end
    end
    if (w && a[1:0] == RegData) inflight.push_back('{due: now + int'(Lat), ch: ch, term: sq_term(d)});
    now++;
  endtask

  task automatic model_reset();
    inflight.delete();
    for (int c = 0; c < int'(NumCh); c++) begin
      m_acc[c] = '0;
      m_cnt[c] = '0;
      m_ovf[c] = 1'b0;
    end
  endtask

  // One bus cycle, entered and left on a falling edge; response checked every cycle.
  task automatic cycle_drive(input logic r, input logic w, input logic [3:0] a,
                             input logic [31:0] d, output logic [31:0] got);
    logic [31:0] exp;
    exp       = r ? model_read(a) : 32'h0;
    read      = r;
    write     = w;
    address   = a;
    writedata = d;
    @(posedge clk);
    model_step(w, a, d);
    @(negedge clk);
    read  = 1'b0;
    write = 1'b0;
    check("rdvalid", {31'b0, readdatavalid}, {31'b0, r});
    check(r ? "rdata" : "rdata_idle", readdata, exp);
    got = readdata;
  endtask

  function automatic logic [3:0] ad(input int ch, input logic [1:0] r);
    return 4'(ch * 4 + int'(r));
  endfunction

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] g;
    cycle_drive(1'b0, 1'b1, a, d, g);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] got);
    cycle_drive(1'b1, 1'b0, a, 32'h0, got);
  endtask

  task automatic idle(input int n);
    logic [31:0] g;
    repeat (n) cycle_drive(1'b0, 1'b0, 4'h0, 32'h0, g);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_rdvalid", {31'b0, readdatavalid}, 32'h0);
    check("rst_rdata", readdata, 32'h0);
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] term;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] exp4 [4];

    tbl[0] = '{32'h0002_0000, 32'h0004_0000};  // 2.0
    tbl[1] = '{32'h0001_0000, 32'h0001_0000};  // 1.0
    tbl[2] = '{32'hFFFF_0000, 32'h0001_0000};  // -1.0
    tbl[3] = '{32'h0000_8000, 32'h0000_4000};  // 0.5
    tbl[4] = '{32'h0001_8000, 32'h0002_4000};  // 1.5
    tbl[5] = '{32'h0003_0000, 32'h0009_0000};  // 3.0
    tbl[6] = '{32'h0000_0001, 32'h0000_0000};  // underflows to 0
    tbl[7] = '{32'h0000_0100, 32'h0000_0001};
    tbl[8] = '{32'h8000_0000, 32'h0000_0000};  // 2^46 keeps only low bits
    tbl[9] = '{32'h7FFF_0000, 32'h0001_0000};

    model_reset();
    repeat (2) @(negedge clk);
    check("init_rdvalid", {31'b0, readdatavalid}, 32'h0);
    check("init_rdata", readdata, 32'h0);
    reset_n = 1'b1;

    for (int a = 0; a < 16; a++) begin
      rd(4'(a), got);
      check("reset_reg", got, 32'h0);
    end

    // Single sample: exact landing cycle.
    wr(ad(0, RegData), 32'h0002_0000);
    idle(int'(Lat) - 2);
    rd(ad(0, RegStatus), got);
    check("lat_busy", got, 32'h0000_0003);
    rd(ad(0, RegResult), got);
    check("lat_early", got, 32'h0);
    rd(ad(0, RegResult), got);
    check("lat_result", got, 32'h0004_0000);
    rd(ad(0, RegStatus), got);
    check("lat_status", got, 32'h0000_0100);

    // Back-to-back samples on one channel.
    wr(ad(1, RegResult), 32'h0);
    for (int i = 0; i < 3; i++) wr(ad(1, RegData), 32'h0001_0000);
    rd(ad(1, RegStatus), got);
    check("b2b_pend3", got, 32'h0000_0007);
    idle(int'(Lat));
    rd(ad(1, RegResult), got);
    check("b2b_result", got, 32'h0003_0000);
    rd(ad(1, RegStatus), got);
    check("b2b_status", got, 32'h0000_0300);

    // Interleaved channels.
    for (int c = 0; c < int'(NumCh); c++) wr(ad(c, RegResult), 32'h0);
    wr(ad(0, RegData), 32'h0003_0000);
    wr(ad(2, RegData), 32'h0002_0000);
    idle(int'(Lat));
    exp4 = '{32'h0009_0000, 32'h0, 32'h0004_0000, 32'h0};
    for (int c = 0; c < int'(NumCh); c++) begin
      rd(ad(c, RegResult), got);
      check("ilv_result", got, exp4[c]);
    end

    // Clear coinciding with the landing term keeps that term.
    wr(ad(0, RegData), 32'h0002_0000);
    idle(int'(Lat) - 1);
    wr(ad(0, RegResult), 32'h0);
    rd(ad(0, RegResult), got);
    check("clr_coinc_result", got, 32'h0004_0000);
    rd(ad(0, RegStatus), got);
    check("clr_coinc_status", got, 32'h0000_0100);

    // Constant table of squares.
    for (int i = 0; i < 10; i++) begin
      wr(ad(i % 4, RegResult), 32'h0);
      wr(ad(i % 4, RegData), tbl[i].x);
      idle(int'(Lat));
      rd(ad(i % 4, RegResult), got);
      check("tbl_result", got, tbl[i].term);
      rd(ad(i % 4, RegStatus), got);
      check("tbl_status", got, 32'h0000_0100);
    end

    // Overflow: 32761.0 + 32761.0.
    wr(ad(3, RegResult), 32'h0);
    wr(ad(3, RegData), 32'h00B5_0000);
    wr(ad(3, RegData), 32'h00B5_0000);
    idle(int'(Lat));
    rd(ad(3, RegResult), got);
`ifdef CORDIC_ACC_SATURATE_EN
    check("ovf_result", got, 32'h7FFF_FFFF);
    rd(ad(3, RegStatus), got);
    check("ovf_status", got, 32'h0100_0200);
`else
    check("ovf_result", got, 32'hFFF2_0000);
    rd(ad(3, RegStatus), got);
    check("ovf_status", got, 32'h0000_0200);
`endif

    // Reserved and DATA registers read as zero; reserved writes are ignored.
    wr(ad(2, RegRsvd), 32'hFFFF_FFFF);
    rd(ad(2, RegRsvd), got);
    check("rsvd_read", got, 32'h0);
    rd(ad(2, RegData), got);
    check("data_read", got, 32'h0);

    // Random traffic against the model.
    for (int c = 0; c < int'(NumCh); c++) wr(ad(c, RegResult), 32'h0);
    for (int i = 0; i < 400; i++) begin
      int          op;
      logic [3:0]  a;
      logic [31:0] d;
      op = int'($urandom_range(0, 7));
      a  = 4'($urandom_range(0, 15));
      d  = 32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
      case (op)
        0, 1, 2: cycle_drive(1'b0, 1'b1, {a[3:2], RegData}, d, got);
        3:       cycle_drive(1'b0, 1'b1, {a[3:2], RegResult}, d, got);
        4:       cycle_drive(1'b0, 1'b1, {a[3:2], 1'b1, a[0]}, d, got);
        5, 6:    cycle_drive(1'b1, 1'b0, a, d, got);
        default: cycle_drive(1'b1, 1'b1, a, d, got);
      endcase
    end
    idle(int'(Lat) + 1);
    for (int a = 0; a < 16; a++) rd(4'(a), got);

    // Reset with samples in flight.
    for (int c = 0; c < int'(NumCh); c++) wr(ad(c, RegData), 32'h0001_0000);
    idle(1);
    do_reset();
    idle(int'(Lat) + 3);
    for (int c = 0; c < int'(NumCh); c++) begin
      rd(ad(c, RegResult), got);
      check("post_rst_result", got, 32'h0);
      rd(ad(c, RegStatus), got);
      check("post_rst_status", got, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
